l2data_axis: RTL and testbench

L2DATA_AXIS -- requirements
Module: l2data_axis

---
 rtl/l2data_axis.sv | 53 +++++
 tb/tb_l2data_axis.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2data_axis.sv
// One way of the L2 data bank: a 2**AW x DW array with per-entry valid bits,
// combinational read and a per-bit masked read-modify-write.
module l2data_axis #(
    parameter int unsigned DW = 156,
    parameter int unsigned AW = 10
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] data_in,
    input  logic          we,
    input  logic [DW-1:0] wm,
    output logic [DW-1:0] data_out
);

    localparam int unsigned DEPTH = 32'd1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [DW-1:0] old_c;
    logic [DW-1:0] merged_c;
    logic          wr_en_c;

    // Invalid entries read as zero; this same value feeds the merge.
    always_comb begin
        old_c    = '0;
        if (valid[adr]) begin
            old_c = mem[adr];
        end
        merged_c = (data_in & wm) | (old_c & ~wm);
        wr_en_c  = we & ~rst;
    end

    // Reads return pre-write contents during a write cycle.
    assign data_out = old_c;

    // Reset only clears valid bits; storage keeps stale data behind them.
    always_ff @(posedge rclk) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[adr] <= 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (wr_en_c) begin
            mem[adr] <= merged_c;
        end
    end

endmodule

// File: tb/tb_l2data_axis.sv
// Self-checking bench for l2data_axis: directed scenarios plus a random
// read/write run against a reference model, checked through a scoreboard queue.
module tb_l2data_axis;

    localparam int unsigned DW    = 156;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    logic          rclk;
    logic          rst;
    logic [AW-1:0] adr;
    logic [DW-1:0] data_in;
    logic          we;
    logic [DW-1:0] wm;
    logic [DW-1:0] data_out;

    l2data_axis #(.DW(DW), .AW(AW)) dut (
        .rclk     (rclk),
        .rst      (rst),
        .adr      (adr),
        .data_in  (data_in),
        .we       (we),
        .wm       (wm),
        .data_out (data_out)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_valid [DEPTH];

    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] ZERO = '0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_valid[a] ? ref_mem[a] : ZERO;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [159:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[DW-1:0];
    endfunction

    // One clock of stimulus; the reference model advances with the edge.
    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
        logic [DW-1:0] old;
        rst = r; we = w; adr = a; data_in = d; wm = m;
        @(posedge rclk);
        #1;
        if (r) begin
            for (int i = 0; i < int'(DEPTH); i++) ref_valid[i] = 1'b0;
        end else if (w) begin
            old = ref_read(a);
            ref_mem[a]   = (d & m) | (old & ~m);
            ref_valid[a] = 1'b1;
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        cyc(1'b1, 1'b0, '0, ZERO, ZERO);
        for (int i = 0; i < int'(DEPTH); i++) begin
            adr = AW'(i);
            exp_q.push_back(ZERO);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL reset_sweep adr=%0d got=%h exp=%h", i, data_out, e);
            end
        end
    endtask

    task automatic test_full_write();
        logic [DW-1:0] e;
        cyc(1'b0, 1'b1, 10'h3FF, ONES, ONES);
        adr = 10'h3FF;
        exp_q.push_back(ONES);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL full_write_3ff got=%h exp=%h", data_out, e);
        end
        adr = 10'h000;
        exp_q.push_back(ZERO);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL full_write_adr0 got=%h exp=%h", data_out, e);
        end
    endtask

    task automatic test_partial_mask();
        logic [DW-1:0] m;
        logic [DW-1:0] e;
        m = {39'h0, 39'h7FFFFFFFFF, 39'h0, 39'h0};
        cyc(1'b0, 1'b1, 10'd5, ONES, ONES);
        cyc(1'b0, 1'b1, 10'd5, ZERO, m);
        adr = 10'd5;
        exp_q.push_back({{39{1'b1}}, 39'h0, {78{1'b1}}});
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL partial_mask got=%h exp=%h", data_out, e);
        end
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] a_val;
        logic [DW-1:0] b_val;
        logic [DW-1:0] e;
        a_val = rand_word();
        b_val = ~a_val;
        cyc(1'b0, 1'b1, 10'd7, a_val, ONES);
        rst = 1'b0; we = 1'b1; adr = 10'd7; data_in = b_val; wm = ONES;
        exp_q.push_back(a_val);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL rdw_before_edge got=%h exp=%h", data_out, e);
        end
        @(posedge rclk);
        #1;
        we = 1'b0;
        ref_mem[7] = b_val;
        ref_valid[7] = 1'b1;
        exp_q.push_back(b_val);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL rdw_after_edge got=%h exp=%h", data_out, e);
        end
    endtask

    task automatic test_invalid_partial();
        logic [DW-1:0] e;
        // Stale all-ones storage behind an invalid entry must not leak.
        cyc(1'b0, 1'b1, 10'd2, ONES, ONES);
        cyc(1'b1, 1'b0, '0, ZERO, ZERO);
        cyc(1'b0, 1'b1, 10'd2, ONES, {117'b0, {39{1'b1}}});
        adr = 10'd2;
        exp_q.push_back({117'b0, {39{1'b1}}});
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL invalid_partial got=%h exp=%h", data_out, e);
        end
    endtask

    task automatic test_wm_zero();
        logic [DW-1:0] v;
        logic [DW-1:0] e;
        v = rand_word();
        cyc(1'b0, 1'b1, 10'd11, v, ONES);
        cyc(1'b0, 1'b1, 10'd11, ~v, ZERO);
        cyc(1'b0, 1'b0, 10'd11, ONES, ONES);
        adr = 10'd11;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (data_out !== e) begin
            n_fail++;
            $display("FAIL wm_zero_and_we0 got=%h exp=%h", data_out, e);
        end
    endtask

    task automatic test_reset_with_write();
        logic [DW-1:0] e;
        logic [AW-1:0] probe [4];
        probe[0] = 10'd9; probe[1] = 10'd3; probe[2] = 10'h3FF; probe[3] = 10'd7;
        cyc(1'b0, 1'b1, 10'd9, rand_word(), ONES);
        cyc(1'b0, 1'b1, 10'd3, ONES, ONES);
        cyc(1'b1, 1'b1, 10'd9, ONES, ONES);
        for (int i = 0; i < 4; i++) begin
            adr = probe[i];
            exp_q.push_back(ZERO);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (data_out !== e) begin
                n_fail++;
                $display("FAIL reset_with_write adr=%0d got=%h exp=%h", probe[i], data_out, e);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        logic [AW-1:0] a;
        logic [DW-1:0] m;
        for (int i = 0; i < 400; i++) begin
            a = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 2))
                    0: m = ONES;
                    1: m = rand_word();
                    default: m = {{39{1'b1}}, 78'h0, {39{1'b1}}};
                endcase
                cyc(1'b0, 1'b1, a, rand_word(), m);
            end else begin
                adr = a;
                exp_q.push_back(ref_read(a));
                #1;
                e = exp_q.pop_front();
                n_checks++;
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL random_read adr=%0d got=%h exp=%h", a, data_out, e);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; we = 1'b0; adr = '0; data_in = '0; wm = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i]   = ZERO;
            ref_valid[i] = 1'b0;
        end
        repeat (2) @(posedge rclk);
        #1;
        test_reset();
        test_full_write();
        test_partial_mask();
        test_read_during_write();
        test_invalid_partial();
        test_wm_zero();
        test_reset_with_write();
        cyc(1'b1, 1'b0, '0, ZERO, ZERO);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
